// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch-PC owner and DEPTH-entry {pc, instr} FIFO between imem and decode.
module instr_fetch_queue #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            fetch_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ILEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [ILEN-1:0] instr_q [DEPTH];
  logic [ILEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic full, empty, push, pop;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    in_ready = !full && !flush && !reset;
    out_valid = !empty && !flush;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    fetch_pc = fetch_pc_q;
    count = count_q;
    out_instr = empty ? '0 : instr_q[rd_ptr_q];
    out_pc = empty ? '0 : pc_q[rd_ptr_q];
    fetch_pc_d = flush ? {flush_pc[XLEN-1:2], 2'b00} : push ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    wr_ptr_d = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    instr_d = instr_q;
    pc_d = pc_q;
    if (push) begin
      instr_d[wr_ptr_q] = in_instr;
      pc_d[wr_ptr_q] = fetch_pc_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // payload needs no reset: outputs are masked while the queue is empty
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q <= pc_d;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Parametrised instruction fetch queue that sits between instruction memory and the decode stage of RiscV_Pipeline_Processor. It replaces direct per-cycle `Instr` driving. It owns the fetch PC and buffers up to DEPTH {pc, instruction} pairs behind valid/ready handshakes. Decode stalls are absorbed through backpressure, and a branch/jump redirect is handled with a single-cycle flush.

Parameters:
XLEN, 64, PC width in bits.
ILEN, 32, instruction width in bits.
DEPTH, 4, queue entries; power of two, minimum 2.
RESET_PC, 64'h0, fetch PC value after reset; bits [1:0] must be 0.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
fetch_pc  out  XLEN  address of the next instruction to accept from memory
in_valid  in  1  in_instr holds the word at fetch_pc
in_ready  out  1  queue accepts in_instr this cycle
in_instr  in  ILEN  instruction word from memory
out_valid  out  1  head entry is available to decode
out_ready  in  1  decode consumes the head entry
out_instr  out  ILEN  head instruction
out_pc  out  XLEN  PC of the head instruction
flush  in  1  redirect request; discards all queued entries
flush_pc  in  XLEN  redirect target
count  out  $clog2(DEPTH+1)  current number of queued entries

Behaviour:
- Reset (asynchronous, active-high): fetch_pc=RESET_PC, count=0, read and write pointers=0, out_valid=0.
- Reset (continued): in_ready=0 while reset is high; out_instr and out_pc=0 while the queue is empty.
- Reset asserted mid-operation drops every entry immediately. The handshake completing in that cycle has no effect.
- Handshake outputs, all combinational from registered state plus flush:
  - in_ready = !full && !flush && !reset.
  - out_valid = (count!=0) && !flush.
  - out_instr and out_pc are driven from the head entry (registered storage); they are 0 when count==0.
- Push (in_valid && in_ready): write {fetch_pc, in_instr} at the write pointer, then advance the write pointer.
  - fetch_pc <= fetch_pc + 4; wraps modulo 2^XLEN.
- Pop (out_valid && out_ready): advance the read pointer.
- Pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
- Full (count==DEPTH):
  - in_ready=0.
  - A pop in that cycle does not enable a push; there is no same-cycle refill. in_ready rises the cycle after the pop.
- Empty (count==0):
  - out_valid=0.
  - There is no bypass: a pushed entry appears on out_valid one cycle after the push (latency 1 cycle).
- Flush (highest priority):
  - Push and pop in the flush cycle are suppressed, because in_ready=0 and out_valid=0 combinationally.
  - Next cycle: count=0, pointers=0, fetch_pc={flush_pc[XLEN-1:2],2'b00}.
  - Back-to-back flushes: the last flush_pc wins.
- in_instr is stored unmodified; the block performs no decode.
- Storage is registers, not RAM, so out_instr/out_pc are valid in the same cycle as out_valid.
- Handshake protocol rules:
  - Upstream must hold in_instr stable while in_valid=1 and in_ready=0.
  - in_valid may drop without a transfer.
  - out_* hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then idle: reset high for 10 ns -> fetch_pc=0, count=0, out_valid=0, in_ready=0 during reset and 1 after release.
- Fill to full: in_valid=1 with in_instr 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233 and out_ready=0 -> count reaches 4, in_ready=0, fetch_pc=16; out_pc=0, out_instr=32'h00500093.
- Drain with stall: from the full state, toggle out_ready 1,0,1,1 -> out_pc sequence 0,4,8,12; count decrements only on the cycles with out_ready=1; in_ready returns to 1 the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with in_instr=pc-tagged words -> count holds at 1 after the first cycle; each word exits exactly 1 cycle after entry with a matching PC.
- Flush mid-stream: with 3 entries queued, pulse flush with flush_pc=64'h100 together with in_valid=1 and out_ready=1 -> no transfer in that cycle; next cycle count=0, out_valid=0, fetch_pc=64'h100; the next push is tagged 64'h100.
- Misaligned flush and wrap: flush_pc=64'hFFFFFFFFFFFFFFFE, then 2 pushes -> fetch_pc goes 64'hFFFFFFFFFFFFFFFC, then 64'h0, then 64'h4. Asserting reset mid-push clears count to 0 asynchronously.
